param_data_cache: RTL

PARAM_DATA_CACHE -- requirements
Module: param_data_cache

---
 rtl/param_data_cache.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/param_data_cache.sv
// -----------------------------------------------------------------------------
// param_data_cache
//   Direct-mapped, write-through, no-write-allocate data cache with a single
//   outstanding memory transaction. A request completes with a one-cycle dc_hit
//   pulse. Requests are not accepted in the cycle that dc_hit is high, so every
//   completion is followed by one bubble cycle.
//
// Parameters
//   SETS  : number of direct-mapped lines (power of two, >= 2)
//   WORDS : 32-bit words per line (power of two, >= 2)
//
// Ports
//   clk            : clock; all state changes on the rising edge
//   rst            : synchronous active-high reset
//   addr           : CPU byte address, bits [1:0] ignored
//   data_write     : CPU store data
//   SigMemRead     : CPU load request, held until dc_hit
//   SigMemWrite    : CPU store request, held until dc_hit (wins over a load)
//   dc_hit         : one-cycle completion pulse
//   data_read      : load data, valid in the dc_hit cycle of a load
//   mem_req        : memory request, held until mem_ack
//   mem_we         : 1 = single-word write, 0 = line fill
//   mem_addr       : line-aligned for a fill, word-aligned for a write
//   mem_write_data : store data for a memory write
//   mem_data       : fill line, word 0 in bits [31:0]
//   mem_ack        : one-cycle memory completion
//   hit_count      : hit statistics counter
//   miss_count     : miss statistics counter
//
// Build option
//   DATA_CACHE_STATS_EN : when defined, hit_count/miss_count count hits and
//                         misses at request acceptance (wrapping). When not
//                         defined, both outputs are tied to zero.
// -----------------------------------------------------------------------------
module param_data_cache #(
    parameter int unsigned SETS  = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [31:0]           data_write,
    input  logic                  SigMemRead,
    input  logic                  SigMemWrite,
    output logic                  dc_hit,
    output logic [31:0]           data_read,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [32*WORDS-1:0]   mem_data,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int unsigned WORD_W = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned OFF    = WORD_W + 2;
    localparam int unsigned TAG_W  = 32 - OFF - IDX_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]        r_state;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [31:0]       r_data [SETS][WORDS];
    logic [WORD_W-1:0] r_fill_word;
    logic [IDX_W-1:0]  r_fill_idx;
    logic [TAG_W-1:0]  r_fill_tag;

    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_accept;
    logic              w_do_write;
    logic              w_do_read;
    logic              w_fill_done;
    logic [31:0]       w_mem_words [WORDS];
    logic              w_unused_addr;

    assign w_word  = addr[OFF-1:2];
    assign w_index = addr[OFF+IDX_W-1:OFF];
    assign w_tag   = addr[31:OFF+IDX_W];
    assign w_unused_addr = ^addr[1:0];

    assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

    // Requests are only looked at in IDLE outside the completion cycle.
    assign w_accept    = (r_state == ST_IDLE) && !dc_hit && (SigMemRead || SigMemWrite);
    assign w_do_write  = w_accept && SigMemWrite;
    assign w_do_read   = w_accept && !SigMemWrite;
    assign w_fill_done = (r_state == ST_FILL) && mem_ack;

    always_comb begin
        for (int i = 0; i < int'(WORDS); i++) begin
            w_mem_words[i] = mem_data[i*32 +: 32];
        end
    end

    // Control path and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_valid        <= '0;
            dc_hit         <= 1'b0;
            data_read      <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            dc_hit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_do_write) begin
                        r_state        <= ST_WRITE;
                        mem_req        <= 1'b1;
                        mem_we         <= 1'b1;
                        mem_addr       <= {addr[31:2], 2'b00};
                        mem_write_data <= data_write;
                    end else if (w_do_read) begin
                        if (w_hit) begin
                            data_read <= r_data[w_index][w_word];
                            dc_hit    <= 1'b1;
                        end else begin
                            r_state  <= ST_FILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {addr[31:OFF], {OFF{1'b0}}};
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_valid[r_fill_idx] <= 1'b1;
                        data_read           <= w_mem_words[r_fill_word];
                        dc_hit              <= 1'b1;
                        mem_req             <= 1'b0;
                        r_state             <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        dc_hit  <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; validity alone decides hits. Updates are
    // suppressed while rst is high so an abandoned fill never lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_do_read && !w_hit) begin
                r_fill_word <= w_word;
                r_fill_idx  <= w_index;
                r_fill_tag  <= w_tag;
            end
            if (w_do_write && w_hit) begin
                r_data[w_index][w_word] <= data_write;
            end
            if (w_fill_done) begin
                r_tag[r_fill_idx] <= r_fill_tag;
                for (int i = 0; i < int'(WORDS); i++) begin
                    r_data[r_fill_idx][i] <= w_mem_words[i];
                end
            end
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
